// File: rtl/cp0_mmu_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the packed
// layout of the TLB entry returned by a TLBR.
package cp0_pkg;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CR_INDEX    = 5'd0;
    localparam logic [4:0] CR_RANDOM   = 5'd1;
    localparam logic [4:0] CR_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CR_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CR_CONTEXT  = 5'd4;
    localparam logic [4:0] CR_WIRED    = 5'd6;
    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_ENTRYHI  = 5'd10;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    // Exception codes that drive address capture
    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_MOD  = 5'd1;
    localparam logic [4:0] EX_TLBL = 5'd2;
    localparam logic [4:0] EX_TLBS = 5'd3;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;

    // tlbr_entry = {vpn2[19], asid[8], g, pfn0[20], c0[3], d0, v0, pfn1[20], c1[3], d1, v1}
    localparam int TLBR_W  = 78;
    localparam int TE_V1   = 0;
    localparam int TE_D1   = 1;
    localparam int TE_C1   = 2;
    localparam int TE_PFN1 = 5;
    localparam int TE_V0   = 25;
    localparam int TE_D0   = 26;
    localparam int TE_C0   = 27;
    localparam int TE_PFN0 = 30;
    localparam int TE_G    = 50;
    localparam int TE_ASID = 51;
    localparam int TE_VPN2 = 59;

    // TLB refill/modify exceptions also load EntryHi.VPN2 and Context.BadVPN2
    function automatic logic is_tlb_ex(input logic [4:0] code);
        return (code == EX_MOD) || (code == EX_TLBL) || (code == EX_TLBS);
    endfunction

    // Address errors load BadVAddr only
    function automatic logic is_addr_ex(input logic [4:0] code);
        return (code == EX_ADEL) || (code == EX_ADES);
    endfunction

endpackage

// File: rtl/cp0_mmu_regfile_if.sv
// MTC0/MFC0 bus plus the writeback-stage commit strobes into CP0.
// Every strobe (mtc0_we, wb_ex, eret_flush, tlbp, tlbr) is a single-cycle
// commit qualified by its own level: the pipeline asserts it for exactly the
// cycle the instruction retires, CP0 always accepts (there is no ready), and
// the effect lands on the next clk edge. rdata has no strobe; it is a pure
// combinational read of c0_addr/c0_sel.
interface cp0_mmu_regfile_if import cp0_pkg::*; #(parameter int TLB_ENTRIES = 16);
    localparam int IDXW = $clog2(TLB_ENTRIES);

    logic              mtc0_we;
    logic [4:0]        c0_addr;
    logic [2:0]        c0_sel;
    logic [31:0]       c0_wdata;
    logic [31:0]       rdata;
    logic              wb_ex;
    logic              wb_bd;
    logic              eret_flush;
    logic [4:0]        wb_excode;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_badvaddr;
    logic              tlbp;
    logic              tlbp_found;
    logic [IDXW-1:0]   tlbp_index;
    logic              tlbr;
    logic [TLBR_W-1:0] tlbr_entry;

    modport master (
        output mtc0_we, c0_addr, c0_sel, c0_wdata,
        output wb_ex, wb_bd, eret_flush, wb_excode, wb_pc, wb_badvaddr,
        output tlbp, tlbp_found, tlbp_index, tlbr, tlbr_entry,
        input  rdata
    );

    modport slave (
        input  mtc0_we, c0_addr, c0_sel, c0_wdata,
        input  wb_ex, wb_bd, eret_flush, wb_excode, wb_pc, wb_badvaddr,
        input  tlbp, tlbp_found, tlbp_index, tlbr, tlbr_entry,
        output rdata
    );
endinterface

// File: rtl/cp0_mmu_regfile_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare, sticky TI.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;

    // Prescaler wraps every COUNT_DIV cycles and bumps Count; MTC0 Count restarts both
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            count <= '0;
        end else if (count_we) begin
            presc <= '0;
            count <= wdata;
        end else if (presc == PMAX) begin
            presc <= '0;
            count <= count + 32'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Compare only changes by MTC0
    always_ff @(posedge clk) begin
        if (reset)           compare <= '0;
        else if (compare_we) compare <= wdata;
    end

    // TI is sticky on equality; a Compare write clears it and masks that cycle's match
    always_ff @(posedge clk) begin
        if (reset)                 ti <= 1'b0;
        else if (compare_we)       ti <= 1'b0;
        else if (count == compare) ti <= 1'b1;
    end
endmodule

// File: rtl/cp0_mmu_regfile.sv
// CP0 register file with MMU support registers, exception capture at WB,
// interrupt pending logic and the MFC0 read mux.
module cp0_mmu_regfile import cp0_pkg::*; #(
    parameter int TLB_ENTRIES = 16,
    parameter int COUNT_DIV   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    cp0_mmu_regfile_if.slave                bus,
    input  logic [5:0]                      ext_int_in,
    output logic [31:0]                     c0_epc,
    output logic [31:0]                     c0_entryhi,
    output logic [31:0]                     c0_entrylo0,
    output logic [31:0]                     c0_entrylo1,
    output logic [31:0]                     c0_index,
    output logic [$clog2(TLB_ENTRIES)-1:0]  c0_random,
    output logic                            has_int
);
    localparam int IDXW = $clog2(TLB_ENTRIES);
    localparam logic [IDXW-1:0] RAND_MAX = IDXW'(TLB_ENTRIES - 1);

    logic [IDXW-1:0] index_idx, random_q, wired_q;
    logic            index_p;
    logic [8:0]      ctx_pte;
    logic [18:0]     ctx_vpn2, ehi_vpn2;
    logic [7:0]      ehi_asid, status_im, cause_ip;
    logic [25:0]     lo0_q, lo1_q;
    logic [31:0]     badvaddr_q, epc_q, count, compare;
    logic            exl, ie, cause_bd, ti;
    logic [4:0]      cause_exc;

    // Only select 0 exists; every other select drops the write
    logic wr;
    assign wr = bus.mtc0_we && (bus.c0_sel == 3'd0);

    logic tlb_cap, bad_cap;
    assign tlb_cap = bus.wb_ex && is_tlb_ex(bus.wb_excode);
    assign bad_cap = bus.wb_ex && (is_tlb_ex(bus.wb_excode) || is_addr_ex(bus.wb_excode));

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr && bus.c0_addr == CR_COUNT),
        .compare_we (wr && bus.c0_addr == CR_COMPARE),
        .wdata      (bus.c0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Status: exception entry sets EXL even when the same cycle carries an MTC0 Status
    always_ff @(posedge clk) begin
        if (reset) begin
            status_im <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
        end else begin
            if (bus.wb_ex)                            exl <= 1'b1;
            else if (bus.eret_flush)                  exl <= 1'b0;
            else if (wr && bus.c0_addr == CR_STATUS)  exl <= bus.c0_wdata[1];
            if (wr && bus.c0_addr == CR_STATUS) begin
                status_im <= bus.c0_wdata[15:8];
                ie        <= bus.c0_wdata[0];
            end
        end
    end

    // Cause: hardware IP sampled every cycle (IP7 folds in TI), BD frozen while EXL is set
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
        end else begin
            cause_ip[7:2] <= {ext_int_in[5] | ti, ext_int_in[4:0]};
            if (wr && bus.c0_addr == CR_CAUSE) cause_ip[1:0] <= bus.c0_wdata[9:8];
            if (bus.wb_ex) begin
                cause_exc <= bus.wb_excode;
                if (!exl) cause_bd <= bus.wb_bd;
            end
        end
    end

    // EPC: a nested exception (EXL already set) keeps the original return address
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= '0;
        end else if (bus.wb_ex) begin
            if (!exl) epc_q <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
        end else if (wr && bus.c0_addr == CR_EPC) begin
            epc_q <= bus.c0_wdata;
        end
    end

    // BadVAddr and Context: faulting-address capture; only PTEBase is software-writable
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= '0;
            ctx_pte    <= '0;
            ctx_vpn2   <= '0;
        end else begin
            if (bad_cap) badvaddr_q <= bus.wb_badvaddr;
            if (tlb_cap) ctx_vpn2   <= bus.wb_badvaddr[31:13];
            if (wr && bus.c0_addr == CR_CONTEXT) ctx_pte <= bus.c0_wdata[31:23];
        end
    end

    // EntryHi: VPN2 priority is TLB exception > MTC0 > TLBR; ASID is MTC0 > TLBR
    always_ff @(posedge clk) begin
        if (reset) begin
            ehi_vpn2 <= '0;
            ehi_asid <= '0;
        end else begin
            if (tlb_cap)                              ehi_vpn2 <= bus.wb_badvaddr[31:13];
            else if (wr && bus.c0_addr == CR_ENTRYHI) ehi_vpn2 <= bus.c0_wdata[31:13];
            else if (bus.tlbr)                        ehi_vpn2 <= bus.tlbr_entry[TE_VPN2 +: 19];
            if (wr && bus.c0_addr == CR_ENTRYHI)      ehi_asid <= bus.c0_wdata[7:0];
            else if (bus.tlbr)                        ehi_asid <= bus.tlbr_entry[TE_ASID +: 8];
        end
    end

    // EntryLo0/1 hold {PFN, C, D, V, G}; TLBR copies the shared G bit into both
    always_ff @(posedge clk) begin
        if (reset) begin
            lo0_q <= '0;
            lo1_q <= '0;
        end else begin
            if (wr && bus.c0_addr == CR_ENTRYLO0) lo0_q <= bus.c0_wdata[25:0];
            else if (bus.tlbr) lo0_q <= {bus.tlbr_entry[TE_PFN0 +: 20], bus.tlbr_entry[TE_C0 +: 3],
                                         bus.tlbr_entry[TE_D0], bus.tlbr_entry[TE_V0],
                                         bus.tlbr_entry[TE_G]};
            if (wr && bus.c0_addr == CR_ENTRYLO1) lo1_q <= bus.c0_wdata[25:0];
            else if (bus.tlbr) lo1_q <= {bus.tlbr_entry[TE_PFN1 +: 20], bus.tlbr_entry[TE_C1 +: 3],
                                         bus.tlbr_entry[TE_D1], bus.tlbr_entry[TE_V1],
                                         bus.tlbr_entry[TE_G]};
        end
    end

    // Index: P reflects the last TLBP outcome; an MTC0 Index beats a same-cycle TLBP hit
    always_ff @(posedge clk) begin
        if (reset) begin
            index_p   <= 1'b0;
            index_idx <= '0;
        end else begin
            if (bus.tlbp) index_p <= ~bus.tlbp_found;
            if (wr && bus.c0_addr == CR_INDEX)   index_idx <= bus.c0_wdata[IDXW-1:0];
            else if (bus.tlbp && bus.tlbp_found) index_idx <= bus.tlbp_index;
        end
    end

    // Wired/Random: Random walks down to Wired then reloads the top entry; a Wired write restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            wired_q  <= '0;
            random_q <= RAND_MAX;
        end else if (wr && bus.c0_addr == CR_WIRED) begin
            wired_q  <= bus.c0_wdata[IDXW-1:0];
            random_q <= RAND_MAX;
        end else if (random_q <= wired_q) begin
            random_q <= RAND_MAX;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    assign c0_epc      = epc_q;
    assign c0_entryhi  = {ehi_vpn2, 5'b0, ehi_asid};
    assign c0_entrylo0 = {6'b0, lo0_q};
    assign c0_entrylo1 = {6'b0, lo1_q};
    assign c0_index    = {index_p, {(31 - IDXW){1'b0}}, index_idx};
    assign c0_random   = random_q;
    assign has_int     = (|(cause_ip & status_im)) & ie & ~exl;

    // MFC0 read mux; unimplemented numbers and nonzero selects read as 0
    always_comb begin
        bus.rdata = '0;
        if (bus.c0_sel == 3'd0) begin
            case (bus.c0_addr)
                CR_INDEX:    bus.rdata = c0_index;
                CR_RANDOM:   bus.rdata = {{(32 - IDXW){1'b0}}, random_q};
                CR_ENTRYLO0: bus.rdata = c0_entrylo0;
                CR_ENTRYLO1: bus.rdata = c0_entrylo1;
                CR_CONTEXT:  bus.rdata = {ctx_pte, ctx_vpn2, 4'b0};
                CR_WIRED:    bus.rdata = {{(32 - IDXW){1'b0}}, wired_q};
                CR_BADVADDR: bus.rdata = badvaddr_q;
                CR_COUNT:    bus.rdata = count;
                CR_ENTRYHI:  bus.rdata = c0_entryhi;
                CR_COMPARE:  bus.rdata = compare;
                CR_STATUS:   bus.rdata = {9'b0, 1'b1, 6'b0, status_im, 6'b0, exl, ie};
                CR_CAUSE:    bus.rdata = {cause_bd, ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};
                CR_EPC:      bus.rdata = epc_q;
                default:     bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_mmu_regfile.sv
// Directed bench for cp0_mmu_regfile with TLB_ENTRIES = 16, COUNT_DIV = 2.
module tb_cp0_mmu_regfile;
    import cp0_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  ext_int_in;
    logic [31:0] c0_epc, c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
    logic [3:0]  c0_random;
    logic        has_int;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rv;

    cp0_mmu_regfile_if #(.TLB_ENTRIES(16)) bus ();

    cp0_mmu_regfile #(.TLB_ENTRIES(16), .COUNT_DIV(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ext_int_in  (ext_int_in),
        .c0_epc      (c0_epc),
        .c0_entryhi  (c0_entryhi),
        .c0_entrylo0 (c0_entrylo0),
        .c0_entrylo1 (c0_entrylo1),
        .c0_index    (c0_index),
        .c0_random   (c0_random),
        .has_int     (has_int)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance n clock edges, land 1 time unit after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        bus.c0_sel  = 3'd0;
        bus.c0_addr = addr;
        #1;
        data = bus.rdata;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        check(tag, d, exp);
    endtask

    task automatic mtc0_sel(input logic [4:0] addr, input logic [2:0] sel, input logic [31:0] data);
        bus.mtc0_we  = 1'b1;
        bus.c0_addr  = addr;
        bus.c0_sel   = sel;
        bus.c0_wdata = data;
        step(1);
        bus.mtc0_we  = 1'b0;
        bus.c0_sel   = 3'd0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_sel(addr, 3'd0, data);
    endtask

    task automatic set_ex(input logic [4:0] code, input logic [31:0] pc, input logic [31:0] bad,
                          input logic bd);
        bus.wb_ex       = 1'b1;
        bus.wb_excode   = code;
        bus.wb_pc       = pc;
        bus.wb_badvaddr = bad;
        bus.wb_bd       = bd;
    endtask

    task automatic clr_ex();
        bus.wb_ex = 1'b0;
        bus.wb_bd = 1'b0;
    endtask

    task automatic eret();
        bus.eret_flush = 1'b1;
        step(1);
        bus.eret_flush = 1'b0;
    endtask

    task automatic tlbp_cmd(input logic found, input logic [3:0] idx);
        bus.tlbp       = 1'b1;
        bus.tlbp_found = found;
        bus.tlbp_index = idx;
    endtask

    initial begin
        reset = 1'b1;
        ext_int_in = '0;
        bus.mtc0_we = 0; bus.c0_addr = 0; bus.c0_sel = 0; bus.c0_wdata = 0;
        bus.wb_ex = 0; bus.wb_bd = 0; bus.eret_flush = 0; bus.wb_excode = 0;
        bus.wb_pc = 0; bus.wb_badvaddr = 0; bus.tlbp = 0; bus.tlbp_found = 0;
        bus.tlbp_index = 0; bus.tlbr = 0; bus.tlbr_entry = '0;
        step(3);

        // reset state, read while reset is still held so the timer cannot move
        chk_reg("rst_index",    CR_INDEX,    32'h0);
        chk_reg("rst_random",   CR_RANDOM,   32'd15);
        chk_reg("rst_entrylo0", CR_ENTRYLO0, 32'h0);
        chk_reg("rst_entrylo1", CR_ENTRYLO1, 32'h0);
        chk_reg("rst_context",  CR_CONTEXT,  32'h0);
        chk_reg("rst_wired",    CR_WIRED,    32'h0);
        chk_reg("rst_badvaddr", CR_BADVADDR, 32'h0);
        chk_reg("rst_count",    CR_COUNT,    32'h0);
        chk_reg("rst_entryhi",  CR_ENTRYHI,  32'h0);
        chk_reg("rst_compare",  CR_COMPARE,  32'h0);
        chk_reg("rst_status",   CR_STATUS,   32'h0040_0000);
        chk_reg("rst_cause",    CR_CAUSE,    32'h0);
        chk_reg("rst_epc",      CR_EPC,      32'h0);
        check("rst_c0_random", {28'h0, c0_random}, 32'd15);
        check("rst_has_int", {31'h0, has_int}, 32'h0);
        check("rst_c0_index", c0_index, 32'h0);

        // Random decrements once per cycle after reset
        reset = 1'b0;
        exp_q = '{32'd14, 32'd13, 32'd12, 32'd11};
        while (exp_q.size() > 0) begin
            step(1);
            check("rand_dec", {28'h0, c0_random}, exp_q.pop_front());
        end
        chk_reg("rand_rdata", CR_RANDOM, 32'd11);

        // unimplemented register number and nonzero select
        mtc0(5'd5, 32'hFFFF_FFFF);
        chk_reg("unimpl_read", 5'd5, 32'h0);
        mtc0_sel(CR_STATUS, 3'd1, 32'h0000_FF03);
        chk_reg("sel1_write_dropped", CR_STATUS, 32'h0040_0000);
        bus.c0_sel = 3'd1; bus.c0_addr = CR_STATUS; #1;
        check("sel1_read", bus.rdata, 32'h0);
        bus.c0_sel = 3'd0;

        // Wired = 4: Random forced to 15, walks 14..4, then reloads 15
        mtc0(CR_WIRED, 32'd4);
        chk_reg("wired_rd", CR_WIRED, 32'd4);
        check("wired_force", {28'h0, c0_random}, 32'd15);
        for (int v = 14; v >= 4; v--) exp_q.push_back(32'(v));
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd14);
        while (exp_q.size() > 0) begin
            step(1);
            check("wired_walk", {28'h0, c0_random}, exp_q.pop_front());
        end

        // Count/Compare with IM7 and IE enabled
        mtc0(CR_STATUS, 32'h0000_8001);
        mtc0(CR_COUNT, 32'h0);
        mtc0(CR_COMPARE, 32'd5);
        rd(CR_CAUSE, rv);
        check("ti_clear_on_cmp", {31'h0, rv[30]}, 32'h0);
        step(9);
        rd(CR_CAUSE, rv);
        check("ti_not_yet", {31'h0, rv[30]}, 32'h0);
        step(1);
        rd(CR_CAUSE, rv);
        check("ti_set", {31'h0, rv[30]}, 32'h1);
        check("has_int_lag", {31'h0, has_int}, 32'h0);
        step(1);
        check("has_int_timer", {31'h0, has_int}, 32'h1);
        rd(CR_CAUSE, rv);
        check("ip7", {31'h0, rv[15]}, 32'h1);
        chk_reg("count_val", CR_COUNT, 32'd6);
        mtc0(CR_COMPARE, 32'h100);
        rd(CR_CAUSE, rv);
        check("ti_cleared", {31'h0, rv[30]}, 32'h0);
        chk_reg("compare_rd", CR_COMPARE, 32'h100);
        mtc0(CR_STATUS, 32'h0);

        // Count wraps to 0 without any flag
        mtc0(CR_COUNT, 32'hFFFF_FFFF);
        chk_reg("count_max", CR_COUNT, 32'hFFFF_FFFF);
        step(2);
        chk_reg("count_wrap", CR_COUNT, 32'h0);

        // external interrupt: has_int lags ext_int_in by one cycle
        mtc0(CR_STATUS, 32'h0000_0401);
        ext_int_in = 6'b000001;
        #1;
        check("ext_int_lag", {31'h0, has_int}, 32'h0);
        step(1);
        check("ext_int_seen", {31'h0, has_int}, 32'h1);
        rd(CR_CAUSE, rv);
        check("ip2", {31'h0, rv[10]}, 32'h1);
        ext_int_in = 6'b0;
        step(1);
        check("ext_int_drop", {31'h0, has_int}, 32'h0);
        mtc0(CR_STATUS, 32'h0);

        // software interrupt bits
        mtc0(CR_CAUSE, 32'h0000_0300);
        rd(CR_CAUSE, rv);
        check("sw_ip", rv & 32'h0000_0300, 32'h0000_0300);
        mtc0(CR_CAUSE, 32'h0);

        // TLBL exception in a delay slot
        set_ex(EX_TLBL, 32'h0000_1000, 32'h8765_4321, 1'b1);
        step(1);
        clr_ex();
        chk_reg("ex_epc", CR_EPC, 32'h0000_0FFC);
        check("ex_c0_epc", c0_epc, 32'h0000_0FFC);
        rd(CR_CAUSE, rv);
        check("ex_bd", {31'h0, rv[31]}, 32'h1);
        check("ex_code", {27'h0, rv[6:2]}, 32'd2);
        chk_reg("ex_status", CR_STATUS, 32'h0040_0002);
        chk_reg("ex_badvaddr", CR_BADVADDR, 32'h8765_4321);
        chk_reg("ex_entryhi", CR_ENTRYHI, 32'h8765_4000);
        chk_reg("ex_context", CR_CONTEXT, 32'h0043_B2A0);
        mtc0(CR_CONTEXT, 32'hFFFF_FFFF);
        chk_reg("ctx_ptebase", CR_CONTEXT, 32'hFFC3_B2A0);

        // nested AdEL while EXL=1: EPC/BD held, ExcCode and BadVAddr update
        set_ex(EX_ADEL, 32'h0000_2000, 32'h0000_1234, 1'b0);
        step(1);
        clr_ex();
        chk_reg("nest_epc", CR_EPC, 32'h0000_0FFC);
        rd(CR_CAUSE, rv);
        check("nest_bd", {31'h0, rv[31]}, 32'h1);
        check("nest_code", {27'h0, rv[6:2]}, 32'd4);
        chk_reg("nest_badvaddr", CR_BADVADDR, 32'h0000_1234);
        chk_reg("nest_entryhi", CR_ENTRYHI, 32'h8765_4000);
        eret();
        chk_reg("eret_status", CR_STATUS, 32'h0040_0000);

        // wb_ex together with MTC0 Status: EXL from the exception, IM/IE from the write
        set_ex(EX_INT, 32'h0000_3000, 32'h0, 1'b0);
        bus.mtc0_we = 1'b1; bus.c0_addr = CR_STATUS; bus.c0_wdata = 32'h0000_FF01;
        step(1);
        clr_ex();
        bus.mtc0_we = 1'b0;
        chk_reg("ex_mtc0_status", CR_STATUS, 32'h0040_FF03);
        chk_reg("ex_mtc0_epc", CR_EPC, 32'h0000_3000);
        eret();
        mtc0(CR_STATUS, 32'h0);

        // wb_ex Mod together with MTC0 EntryHi: VPN2 from badvaddr, ASID from the write
        set_ex(EX_MOD, 32'h0000_4000, 32'hFFFF_E000, 1'b0);
        bus.mtc0_we = 1'b1; bus.c0_addr = CR_ENTRYHI; bus.c0_wdata = 32'h0000_0011;
        step(1);
        clr_ex();
        bus.mtc0_we = 1'b0;
        chk_reg("ex_mtc0_entryhi", CR_ENTRYHI, 32'hFFFF_E011);
        chk_reg("ex_mod_context", CR_CONTEXT, 32'hFFFF_FFF0);
        eret();

        // TLBP miss, hit, and hit racing an MTC0 Index
        tlbp_cmd(1'b0, 4'd0);
        step(1);
        bus.tlbp = 1'b0;
        chk_reg("tlbp_miss", CR_INDEX, 32'h8000_0000);
        tlbp_cmd(1'b1, 4'd7);
        step(1);
        bus.tlbp = 1'b0;
        chk_reg("tlbp_hit", CR_INDEX, 32'd7);
        check("tlbp_c0_index", c0_index, 32'd7);
        tlbp_cmd(1'b1, 4'd9);
        bus.mtc0_we = 1'b1; bus.c0_addr = CR_INDEX; bus.c0_wdata = 32'd3;
        step(1);
        bus.tlbp = 1'b0;
        bus.mtc0_we = 1'b0;
        chk_reg("mtc0_beats_tlbp", CR_INDEX, 32'd3);

        // TLBR: vpn2=2AAAA asid=5C g=1 pfn0=ABCDE c0=3 d0=1 v0=0 pfn1=12345 c1=5 d1=0 v1=1
        bus.tlbr = 1'b1;
        bus.tlbr_entry = {19'h2AAAA, 8'h5C, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b0,
                          20'h12345, 3'd5, 1'b0, 1'b1};
        step(1);
        bus.tlbr = 1'b0;
        chk_reg("tlbr_entryhi", CR_ENTRYHI, 32'h5555_405C);
        chk_reg("tlbr_entrylo0", CR_ENTRYLO0, 32'h02AF_379D);
        chk_reg("tlbr_entrylo1", CR_ENTRYLO1, 32'h0048_D16B);
        check("tlbr_c0_entryhi", c0_entryhi, 32'h5555_405C);
        check("tlbr_c0_entrylo1", c0_entrylo1, 32'h0048_D16B);

        // EntryLo writable field mask
        mtc0(CR_ENTRYLO0, 32'hFFFF_FFFF);
        check("entrylo0_mask", c0_entrylo0, 32'h03FF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cp0_mmu_regfile.md
# cp0_mmu_regfile

Parametrised CP0 register file for the MIPS pipeline, succeeding the fixed 16-entry design. TLB depth and timer rate are parameters. It adds Random, Wired and Context registers, and captures TLB-exception state (BadVAddr, EntryHi.VPN2, Context.BadVPN2) at writeback. The block sits beside the WB stage and feeds the TLB, exception-redirect logic and MFC0 read path.

## Interface
- TLB_ENTRIES, 16: TLB depth, power of two, 2..64; IDXW = $clog2(TLB_ENTRIES)
- COUNT_DIV, 2: clk cycles per Count increment, ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mtc0_we  in  1  MTC0 commit at WB
- c0_addr  in  5  register number (read and write)
- c0_sel  in  3  select; only sel 0 implemented, others read 0 and ignore writes
- c0_wdata  in  32  MTC0 data
- wb_ex, wb_bd, eret_flush  in  1 each  exception commit, branch-delay flag, ERET commit
- wb_excode  in  5  exception code
- wb_pc, wb_badvaddr  in  32 each  faulting PC, faulting address
- ext_int_in  in  6  hardware interrupts, level, already synchronised
- tlbp, tlbp_found  in  1 each  TLBP commit, hit flag
- tlbp_index  in  IDXW  hit index
- tlbr  in  1  TLBR commit
- tlbr_entry  in  78  packed {vpn2[19], asid[8], g, pfn0[20], c0[3], d0, v0, pfn1[20], c1[3], d1, v1}
- rdata  out  32  combinational read of the addressed register
- c0_epc, c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index  out  32 each  live register values
- c0_random  out  IDXW  TLBWR index
- has_int  out  1  interrupt pending and enabled

## Operation
- All writes land at the next clk edge. Per-field priority: reset > wb_ex > eret_flush > mtc0 > tlbr/tlbp.
- Status: BEV = 1 (constant), IM[15:8], EXL, IE. Reset: IM = 0, EXL = 0, IE = 0. wb_ex sets EXL; eret_flush clears it.
- Cause: BD, TI, IP[15:8], ExcCode.
  - BD and EPC update only on wb_ex with EXL = 0. EPC = wb_bd ? wb_pc−4 : wb_pc.
  - IP[7:2] is registered from {ext_int_in[5]|TI, ext_int_in[4:0]} every cycle.
  - IP[1:0] is software-writable.
- Exception capture:
  - ExcCode in {1 Mod, 2 TLBL, 3 TLBS}: load BadVAddr, EntryHi.VPN2 ← badvaddr[31:13], Context.BadVPN2[22:4] ← badvaddr[31:13].
  - ExcCode in {4 AdEL, 5 AdES}: load BadVAddr only.
- Context: PTEBase[31:23] is writable; [3:0] = 0.
- Index:
  - P[31] is set by tlbp with miss and cleared by tlbp with hit.
  - Index[IDXW-1:0] is written by MTC0 or by tlbp hit.
- Random:
  - Resets to TLB_ENTRIES−1 and decrements every cycle.
  - When Random ≤ Wired, it reloads TLB_ENTRIES−1 on the next edge.
  - Any Wired write also forces Random = TLB_ENTRIES−1.
  - Random is read-only.
- Wired: IDXW bits, reset 0.
- EntryLo0/1 and EntryHi are loaded from tlbr_entry on tlbr. G is written into both EntryLo G bits.
- Count/Compare:
  - A prescaler counts 0..COUNT_DIV−1; Count increments when it wraps.
  - An MTC0 Count write loads Count and clears the prescaler.
  - An MTC0 Compare write loads Compare and clears TI.
  - TI is set (sticky) when Count == Compare and no Compare write happens that cycle.
- has_int = |(IP & IM) & IE & ~EXL.
- Unimplemented register numbers read 0; writes to them are dropped.

## Timing
- rdata is combinational from current state. An MTC0 is visible to a read one cycle later.
- IP[7:2] lags ext_int_in by 1 cycle, so has_int lags ext_int_in by 1 cycle.
- TI sets 1 cycle after equality; IP7 follows 1 cycle later; has_int rises 2 cycles after Count reaches Compare.
- Reset values:
  - All outputs 0, except Status.BEV = 1 and c0_random = TLB_ENTRIES−1.
  - EPC, BadVAddr and Compare also reset to 0.
- Simultaneous events:
  - wb_ex with mtc0 Status: EXL = 1, IE/IM take the MTC0 value.
  - mtc0 EntryHi with wb_ex TLB exception: VPN2 takes badvaddr.
  - mtc0 Index with tlbp hit: MTC0 wins.
- Count wraps 0xFFFFFFFF → 0 with no flag.

## Structure
- Package cp0_pkg holds:
  - CR_* register numbers (Index 0, Random 1, EntryLo0 2, EntryLo1 3, Context 4, Wired 6, BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14)
  - EX_* exception codes
  - the tlbr_entry packed width and field offsets
- One sub-module, cp0_timer, holds prescaler, Count, Compare and TI. Parameter COUNT_DIV; ports clk, reset, count_we, compare_we, wdata, count, compare, ti.

## Test plan
- Reset, then read all registers → Status = 0x0040_0000, Random = TLB_ENTRIES−1, all others 0; Random decrements by one each cycle after reset.
- Write Wired = 4 (TLB_ENTRIES = 16) → Random reloads to 15, counts 15..4, then 15 again.
- Exception: wb_ex, excode 2, badvaddr 0x8765_4321, wb_bd = 1, pc 0x1000 →
  - EPC = 0xFFC, Cause.BD = 1, ExcCode = 2, EXL = 1
  - BadVAddr = 0x8765_4321, EntryHi[31:13] = 0x43B2A, Context[22:4] = 0x43B2A
- Second wb_ex while EXL = 1 → EPC and BD unchanged, ExcCode updated.
- Count/Compare: COUNT_DIV = 2, write Count = 0, Compare = 5 → TI = 1 after 10–11 cycles; with IM7 = 1, IE = 1, has_int = 1 two cycles later; writing Compare clears TI.
- tlbp miss → Index = 0x8000_0000; tlbp hit at 7 → Index = 7; tlbr with a packed entry → EntryHi/EntryLo0/EntryLo1 match its fields, G set in both EntryLo registers.
